pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard and sequencing controller for the five-stage MIPS pipeline (F/D/E/M/W). It merges the memory handshake stalls, the decode load-use stall and the multi-cycle mult/div occupancy into per-register stall/flush enables. It also holds a taken-branch redirect until fetch can accept it. It is instantiated once in `mycpu_top`, beside the stage modules.

## Interface
- `MULT_CYCLES`, default 4: cycles `E` is held for MULT/MULTU (≥1).
- `DIV_CYCLES`, default 32: cycles `E` is held for DIV/DIVU (≥1).
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous, active-low.
- `i_req` / `i_data_ok` in 1/1: fetch request outstanding / fetch data returned this cycle.
- `d_req` / `d_data_ok` in 1/1: M-stage data request / data returned this cycle.
- `load_use` in 1: decode load-use hazard.
- `branch_taken` in 1: decode resolved a taken branch or jump.
- `branch_target` in 32: its target PC.
- `md_start` / `md_is_div` in 1/1: E holds a mult/div instruction; 1 selects DIV timing.
- `stall_f`, `stall_d`, `stall_e`, `stall_m` out 1: hold the pipeline register of that stage.
- `flush_d`, `flush_e`, `flush_m`, `flush_w` out 1: load a bubble into that register at the next edge.
- `redirect_valid` out 1: fetch takes `redirect_pc` as its next PC.
- `redirect_pc` out 32: redirect target.
- `md_busy` / `md_done` out 1/1: mult/div unit running / result valid.
- `perf_stall_cycles`, `perf_redirects` out 32/32: performance counters (see Configuration).

## Operation
- Stall causes, evaluated combinationally, highest priority first:
  - dstall = `d_req & ~d_data_ok`: stall F,D,E,M; flush W.
  - mdstall = E-hold from the mult/div FSM: stall F,D,E; flush M.
  - lustall = `load_use`: stall F,D; flush E.
  - istall = `i_req & ~i_data_ok`: stall F; flush D.
- Outputs are the OR of all active causes.
- A flush is suppressed on any register that is also stalled, so stall wins.
- Mult/div FSM, states MD_IDLE, MD_RUN, MD_DONE:
  - MD_IDLE with `md_start`: mdstall=1. At the edge, `cnt` ← (`md_is_div` ? DIV_CYCLES : MULT_CYCLES) − 1 and the FSM goes to MD_RUN. With `cnt`=0 it goes directly to MD_DONE.
  - MD_RUN: mdstall=1, `md_busy`=1, `cnt` decrements every cycle regardless of other stalls. At `cnt`=1 the FSM goes to MD_DONE.
  - MD_DONE: `md_done`=1, mdstall=0. The FSM goes to MD_IDLE at the first edge with `stall_e`=0. `md_start` is ignored in this state, so a held instruction never restarts.
  - `cnt` is 6 bits; N=DIV_CYCLES gives exactly N mdstall cycles.
- Redirect FSM, states RD_IDLE, RD_PEND:
  - A branch is accepted only when `branch_taken & ~stall_d`. A stalled D re-presents the branch later.
  - Accepted with `stall_f`=0: `redirect_valid`=1 and `redirect_pc`=`branch_target` in the same cycle. The FSM stays in RD_IDLE.
  - Accepted with `stall_f`=1: `branch_target` is latched and the FSM goes to RD_PEND.
  - RD_PEND: `redirect_valid`=1, `redirect_pc`=latched value. Return to RD_IDLE at the first edge with `stall_f`=0.
  - New branches are ignored in RD_PEND; D holds only the delay slot or a bubble there.
- The delay slot is never flushed by a branch.

## Timing
- Reset values: all FSMs IDLE, `cnt`=0, latched PC=0, all outputs 0, perf counters 0.
- Reset asserted mid-operation aborts mult/div and the pending redirect immediately.
- Stall/flush outputs are combinational from inputs and state, with zero latency.
- MULT issued at cycle t with no other stalls:
  - mdstall is high in cycles t..t+3.
  - `md_done` is high in cycle t+4.
  - E advances at the end of t+4.
- `md_busy` is high in MD_RUN only.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` increments every cycle with `stall_f`=1.
  - `perf_redirects` increments on each cycle with `redirect_valid & ~stall_f`.
  - Both wrap at 2^32.
- `PIPE_CTRL_PERF_EN` undefined: both outputs are tied to 0 and no counter flops are built.

## Test plan
- `d_req`=1, `d_data_ok`=0 for 3 cycles, then 1 → stall F/D/E/M and flush W for 3 cycles, then all 0.
- `md_start`=1, `md_is_div`=1 at cycle 0 → `stall_e`=1 for cycles 0..31; `md_done`=1 at cycle 32. With dstall also at cycle 32, `md_done` holds and no restart occurs.
- `load_use`=1 and `istall` together → `stall_f`/`stall_d`=1, `flush_e`=1, `flush_d`=0 (suppressed).
- `branch_taken`, target 0xBFC00100, during a 2-cycle istall → RD_PEND; `redirect_valid`=1 for 3 cycles; return to RD_IDLE after `i_data_ok`.
- `branch_taken` with dstall active → not accepted; accepted in the first cycle dstall drops, with `redirect_valid` in that cycle.
- `resetn` low during MD_RUN → `md_busy`=0 and `stall_e`=0 immediately; with `PIPE_CTRL_PERF_EN`, counters read 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - hazard and sequencing controller for the F/D/E/M/W pipeline.
//
// Merges memory handshake stalls, the decode load-use stall and mult/div
// occupancy into per-register stall/flush enables, and holds a taken-branch
// redirect until fetch can accept it.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (builds the perf counters;
// when undefined the perf outputs are tied to zero).
//
// Ports:
//   clk, resetn                  clock, async active-low reset
//   i_req, i_data_ok             fetch request outstanding / fetch data returned
//   d_req, d_data_ok             M-stage data request / data returned
//   load_use                     decode load-use hazard
//   branch_taken, branch_target  decode taken branch and its target PC
//   md_start, md_is_div          E holds a mult/div op; 1 selects DIV timing
//   stall_f/d/e/m                hold the stage pipeline register
//   flush_d/e/m/w                load a bubble into the stage register
//   redirect_valid, redirect_pc  fetch takes redirect_pc as next PC
//   md_busy, md_done             mult/div running / result valid
//   perf_stall_cycles            cycles with stall_f
//   perf_redirects               redirects consumed by fetch
//
// Mult/div FSM
//   state   | meaning
//   MD_IDLE | no op in flight; md_start stalls E and loads the counter
//   MD_RUN  | counting down, E held
//   MD_DONE | result valid, waits for E to advance
// Redirect FSM
//   state   | meaning
//   RD_IDLE | no redirect held; accepted branch redirects immediately
//   RD_PEND | latched target presented until fetch is unstalled

module pipe_ctrl #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_data_ok,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        md_start,
    input  logic        md_is_div,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_m,
    output logic        flush_w,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        md_busy,
    output logic        md_done,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_redirects
);

    typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_e;
    typedef enum logic       {RD_IDLE, RD_PEND}         rd_state_e;

    localparam logic [5:0] MULT_LAST = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_LAST  = 6'(DIV_CYCLES - 1);

    md_state_e   md_state_q;
    logic [5:0]  md_cnt_q;
    rd_state_e   rd_state_q;
    logic [31:0] rd_pc_q;

    logic        dstall, mdstall, lustall, istall;
    logic        br_accept;
    logic [5:0]  md_load;

    // Causes are gated by resetn so every output reads 0 while reset is held,
    // even if md_start or a handshake input is still asserted.
    always_comb begin
        dstall  = resetn && d_req && !d_data_ok;
        mdstall = resetn && ((md_state_q == MD_IDLE && md_start) || md_state_q == MD_RUN);
        lustall = resetn && load_use;
        istall  = resetn && i_req && !i_data_ok;
        md_load = md_is_div ? DIV_LAST : MULT_LAST;
    end

    // Each cause stalls its own stage and everything upstream; stall wins
    // over flush on the same register.
    always_comb begin
        stall_m = dstall;
        stall_e = stall_m || mdstall;
        stall_d = stall_e || lustall;
        stall_f = stall_d || istall;
        flush_w = dstall;
        flush_m = mdstall && !stall_m;
        flush_e = lustall && !stall_e;
        flush_d = istall  && !stall_d;
    end

    assign md_busy = (md_state_q == MD_RUN);
    assign md_done = (md_state_q == MD_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
        end else begin
            case (md_state_q)
                MD_IDLE: if (md_start) begin
                    md_cnt_q   <= md_load;
                    md_state_q <= (md_load == 6'd0) ? MD_DONE : MD_RUN;
                end
                MD_RUN: begin
                    md_cnt_q <= md_cnt_q - 6'd1;
                    if (md_cnt_q == 6'd1) md_state_q <= MD_DONE;
                end
                MD_DONE: if (!stall_e) md_state_q <= MD_IDLE;
                default: md_state_q <= MD_IDLE;
            endcase
        end
    end

    // A stalled D re-presents its branch later, so only an advancing D is
    // accepted. In RD_PEND, D holds only the delay slot or a bubble.
    assign br_accept = resetn && branch_taken && !stall_d && (rd_state_q == RD_IDLE);

    always_comb begin
        redirect_valid = br_accept || (rd_state_q == RD_PEND);
        if (rd_state_q == RD_PEND) redirect_pc = rd_pc_q;
        else if (br_accept)        redirect_pc = branch_target;
        else                       redirect_pc = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state_q <= RD_IDLE;
            rd_pc_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (br_accept && stall_f) begin
                    rd_pc_q    <= branch_target;
                    rd_state_q <= RD_PEND;
                end
                RD_PEND: if (!stall_f) rd_state_q <= RD_IDLE;
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_redir_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            if (stall_f)                    perf_stall_q <= perf_stall_q + 32'd1;
            if (redirect_valid && !stall_f) perf_redir_q <= perf_redir_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_redirects    = perf_redir_q;
`else
    assign perf_stall_cycles = '0;
    assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_data_ok, d_req, d_data_ok, load_use;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        md_start, md_is_div;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        md_busy, md_done;
    logic [31:0] perf_stall_cycles, perf_redirects;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_data_ok(d_data_ok),
        .load_use(load_use),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .md_start(md_start), .md_is_div(md_is_div),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .md_busy(md_busy), .md_done(md_done),
        .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
    );

    // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w}
    function automatic logic [7:0] sf_vec();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge and are
    // sampled another unit later, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        i_req = 0; i_data_ok = 0; d_req = 0; d_data_ok = 0; load_use = 0;
        branch_taken = 0; branch_target = '0; md_start = 0; md_is_div = 0;
        #3;
        chk("reset_sf", {24'd0, sf_vec()}, 32'h00);
        chk("reset_redir", {31'd0, redirect_valid}, 32'd0);
        chk("reset_md", {30'd0, md_busy, md_done}, 32'd0);
        chk("reset_perf_s", perf_stall_cycles, 32'd0);
        chk("reset_perf_r", perf_redirects, 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // Data-side stall for three cycles, then data returns.
        d_req = 1; d_data_ok = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("dstall_c%0d", c), {24'd0, sf_vec()}, 32'hF1);
            tick();
        end
        d_data_ok = 1; settle();
        chk("dstall_ok", {24'd0, sf_vec()}, 32'h00);
        tick();
        d_req = 0; d_data_ok = 0;

        // DIV: 32 stall cycles, done in cycle 32 overlapped with a dstall.
        md_start = 1; md_is_div = 1;
        for (int c = 0; c < 32; c++) begin
            settle();
            chk($sformatf("div_sf_c%0d", c), {24'd0, sf_vec()}, 32'hE2);
            chk($sformatf("div_busy_c%0d", c), {31'd0, md_busy}, (c == 0) ? 32'd0 : 32'd1);
            tick();
        end
        d_req = 1; d_data_ok = 0; settle();
        chk("div_done_c32", {30'd0, md_busy, md_done}, 32'd1);
        chk("div_dstall_c32", {24'd0, sf_vec()}, 32'hF1);
        tick();
        d_req = 0; settle();
        chk("div_hold_c33", {31'd0, md_done}, 32'd1);
        chk("div_norestart_c33", {24'd0, sf_vec()}, 32'h00);
        tick();
        md_start = 0; settle();
        chk("div_idle_c34", {30'd0, md_busy, md_done}, 32'd0);
        tick();

        // MULT: stall cycles 0..3, done in cycle 4, E advances after it.
        md_start = 1; md_is_div = 0;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk($sformatf("mult_stall_c%0d", c), {31'd0, stall_e}, 32'd1);
            tick();
        end
        settle();
        chk("mult_done_c4", {29'd0, stall_e, md_busy, md_done}, 32'd1);
        tick();
        md_start = 0; settle();
        chk("mult_idle_c5", {30'd0, md_busy, md_done}, 32'd0);
        tick();

        // Load-use together with an instruction-side stall.
        load_use = 1; i_req = 1; i_data_ok = 0; settle();
        chk("lu_istall", {24'd0, sf_vec()}, 32'hC4);
        tick();
        load_use = 0; settle();
        chk("istall_only", {24'd0, sf_vec()}, 32'h88);
        tick();

        // Branch during a two-cycle instruction stall goes pending.
        branch_taken = 1; branch_target = 32'hBFC0_0100; settle();
        chk("br_pend_c0_v", {31'd0, redirect_valid}, 32'd1);
        chk("br_pend_c0_pc", redirect_pc, 32'hBFC0_0100);
        tick();
        branch_taken = 1; branch_target = 32'h0000_1234; settle();
        chk("br_pend_c1_v", {31'd0, redirect_valid}, 32'd1);
        chk("br_pend_c1_pc", redirect_pc, 32'hBFC0_0100);
        tick();
        branch_taken = 0; i_data_ok = 1; settle();
        chk("br_pend_c2_v", {31'd0, redirect_valid}, 32'd1);
        chk("br_pend_c2_pc", redirect_pc, 32'hBFC0_0100);
        chk("br_pend_c2_sf", {31'd0, stall_f}, 32'd0);
        tick();
        i_req = 0; i_data_ok = 0; settle();
        chk("br_pend_idle", {31'd0, redirect_valid}, 32'd0);
        tick();

        // Branch held off by dstall, accepted when the stall drops.
        d_req = 1; d_data_ok = 0; branch_taken = 1; branch_target = 32'h8000_1000;
        for (int c = 0; c < 2; c++) begin
            settle();
            chk($sformatf("br_dstall_c%0d", c), {31'd0, redirect_valid}, 32'd0);
            tick();
        end
        d_data_ok = 1; settle();
        chk("br_accept_v", {31'd0, redirect_valid}, 32'd1);
        chk("br_accept_pc", redirect_pc, 32'h8000_1000);
        tick();
        d_req = 0; d_data_ok = 0; branch_taken = 0; settle();
        chk("br_accept_idle", {31'd0, redirect_valid}, 32'd0);
`ifndef PIPE_CTRL_PERF_EN
        chk("perf_off_s", perf_stall_cycles, 32'd0);
        chk("perf_off_r", perf_redirects, 32'd0);
`endif
        tick();

        // Reset asserted while the divider runs.
        md_start = 1; md_is_div = 1;
        tick(); tick(); settle();
        chk("rst_pre_busy", {31'd0, md_busy}, 32'd1);
        resetn = 1'b0; settle();
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_stall_e", {31'd0, stall_e}, 32'd0);
        chk("rst_perf_s", perf_stall_cycles, 32'd0);
        chk("rst_perf_r", perf_redirects, 32'd0);
        md_start = 0;
        tick();
        resetn = 1'b1;
        tick(); settle();
        chk("rst_after_md", {30'd0, md_busy, md_done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
